// File: rtl/if_id_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue_pkg
// Brief    : Shared width, fill-NOP constant and queue entry type for the
//            fetch-to-decode instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
package if_id_queue_pkg;

  localparam int c_XLEN = 32;
  localparam logic [c_XLEN-1:0] c_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [c_XLEN-1:0] pc;
    logic [c_XLEN-1:0] insr;
  } queue_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_id_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue_if
// Brief    : Fetch/decode handshake bundle for the instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int XLEN  = c_XLEN,
  parameter int DEPTH = 4
);

  logic                     flush;
  logic                     in_valid;
  logic                     in_bubble;
  logic [XLEN-1:0]          in_pc;
  logic [XLEN-1:0]          in_insr;
  logic                     in_ready;
  logic                     out_valid;
  logic [XLEN-1:0]          out_pc;
  logic [XLEN-1:0]          out_insr;
  logic                     out_rvc;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;

  // master: fetch + decode side; slave: the queue itself
  modport master (
    output flush, in_valid, in_bubble, in_pc, in_insr, out_ready,
    input  in_ready, out_valid, out_pc, out_insr, out_rvc, count
  );

  modport slave (
    input  flush, in_valid, in_bubble, in_pc, in_insr, out_ready,
    output in_ready, out_valid, out_pc, out_insr, out_rvc, count
  );

endinterface
`default_nettype wire

// File: rtl/if_id_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : First-word-fall-through FIFO with sync active-low reset and flush.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     flush,
  input  wire logic                     wr_en,
  input  wire logic [WIDTH-1:0]         wr_data,
  input  wire logic                     rd_en,
  output logic      [WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count
);

  localparam int               c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  // Full blocks writes even if a read frees a slot in the same cycle
  assign w_wr = wr_en & ~full  & ~flush;
  assign w_rd = rd_en & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = (r_count == c_FULL);
  assign empty   = (r_count == '0);
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Brief    : IF->ID instruction queue: bubble filter, flush, NOP fill, RVC flag.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = c_XLEN
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  if_id_queue_if.slave  q
);

  queue_entry_t     w_wr_entry;
  queue_entry_t     w_head;
  logic [XLEN-1:0]  w_head_insr;
  logic             w_wr;
  logic             w_rd;
  logic             w_full;
  logic             w_empty;

  assign w_wr = q.in_valid  & q.in_ready  & ~q.in_bubble & ~q.flush;
  assign w_rd = q.out_valid & q.out_ready & ~q.flush;

  assign w_wr_entry.pc   = q.in_pc;
  assign w_wr_entry.insr = q.in_insr;

  sync_fifo #(
    .WIDTH ($bits(queue_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (q.flush),
    .wr_en   (w_wr),
    .wr_data (w_wr_entry),
    .rd_en   (w_rd),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (q.count)
  );

  // Empty queue presents a harmless NOP so decode never sees stale storage
  assign w_head_insr = w_empty ? c_NOP : w_head.insr;

  assign q.in_ready  = ~w_full;
  assign q.out_valid = ~w_empty;
  assign q.out_pc    = w_empty ? '0 : w_head.pc;
  assign q.out_insr  = w_head_insr;
  assign q.out_rvc   = ~w_empty & (w_head_insr[1:0] != 2'b11);

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_queue
// Brief    : Directed scoreboard bench for the IF->ID instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insr;
    logic        rvc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  if_id_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic [31:0] pc, input logic [31:0] insr);
    bus.in_valid  = v;
    bus.in_bubble = b;
    bus.in_pc     = pc;
    bus.in_insr   = insr;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] insr, input logic rvc);
    exp_t e;
    e.pc   = pc;
    e.insr = insr;
    e.rvc  = rvc;
    sb.push_back(e);
  endtask

  // One stored write, then the input goes idle
  task automatic write(input logic [31:0] pc, input logic [31:0] insr, input logic rvc);
    drive(1'b1, 1'b0, pc, insr);
    push(pc, insr, rvc);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: every consumed head is compared with the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && !bus.flush && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc 0x%08h expected no entry", bus.out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("head_pc",   bus.out_pc,         e.pc);
        check("head_insr", bus.out_insr,       e.insr);
        check("head_rvc",  {31'b0, bus.out_rvc}, {31'b0, e.rvc});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Reset then idle
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'h1);
    check("rst_count",     {29'b0, bus.count},     32'h0);
    check("rst_out_insr",  bus.out_insr,           32'h0000_0013);
    check("rst_out_pc",    bus.out_pc,             32'h0);
    check("rst_out_rvc",   {31'b0, bus.out_rvc},   32'h0);

    // Two writes incl. an RVC word, no in->out combinational path
    drive(1'b1, 1'b0, 32'h100, 32'h0050_0093);
    #1;
    check("no_comb_valid", {31'b0, bus.out_valid}, 32'h0);
    push(32'h100, 32'h0050_0093, 1'b0);
    cyc();
    check("wr_latency_valid", {31'b0, bus.out_valid}, 32'h1);
    write(32'h104, 32'h0000_0001, 1'b1);
    check("two_count",    {29'b0, bus.count},   32'h2);
    check("two_out_insr", bus.out_insr,         32'h0050_0093);
    check("two_out_rvc",  {31'b0, bus.out_rvc}, 32'h0);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("pop1_out_pc",  bus.out_pc,           32'h104);
    check("pop1_out_rvc", {31'b0, bus.out_rvc}, 32'h1);
    check("pop1_count",   {29'b0, bus.count},   32'h1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("pop2_count",   {29'b0, bus.count},   32'h0);

    // Fill to DEPTH, extra words dropped, even with a same-cycle read
    for (int i = 0; i < 4; i++) write(32'h300 + 32'(4 * i), 32'h0010_0093 + 32'(i << 20), 1'b0);
    check("full_count",    {29'b0, bus.count},    32'h4);
    check("full_in_ready", {31'b0, bus.in_ready}, 32'h0);
    drive(1'b1, 1'b0, 32'h400, 32'h0000_0093);
    cyc();
    check("full_drop_count", {29'b0, bus.count}, 32'h4);
    bus.out_ready = 1'b1;
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("full_no_bypass_count", {29'b0, bus.count}, 32'h3);
    repeat (3) cyc();
    bus.out_ready = 1'b0;
    check("drain_count", {29'b0, bus.count}, 32'h0);

    // Steady simultaneous write/read across pointer wrap
    write(32'h500, 32'h0000_0113, 1'b0);
    write(32'h504, 32'h0000_4501, 1'b1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 32'h508 + 32'(4 * i), 32'h0000_0193);
      push(32'h508 + 32'(4 * i), 32'h0000_0193, 1'b0);
      cyc();
      check("steady_count", {29'b0, bus.count}, 32'h2);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) cyc();
    bus.out_ready = 1'b0;
    check("steady_drain_count", {29'b0, bus.count}, 32'h0);

    // Flush beats a concurrent write and read
    for (int i = 0; i < 3; i++) write(32'h600 + 32'(4 * i), 32'h0000_0213, 1'b0);
    check("preflush_count", {29'b0, bus.count}, 32'h3);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h200, 32'h0000_0113);
    sb.delete();
    cyc();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("flush_count",     {29'b0, bus.count},     32'h0);
    check("flush_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("flush_out_insr",  bus.out_insr,           32'h0000_0013);
    cyc();
    check("flush_dropped_count", {29'b0, bus.count}, 32'h0);

    // Write into empty queue with out_ready high is not consumed that cycle
    bus.out_ready = 1'b1;
    write(32'h700, 32'h00A0_0093, 1'b0);
    check("empty_wr_count", {29'b0, bus.count}, 32'h1);
    cyc();
    bus.out_ready = 1'b0;
    check("empty_wr_pop_count", {29'b0, bus.count}, 32'h0);

    // Bubble dropped; reset mid-stream discards entries
    drive(1'b1, 1'b1, 32'h800, 32'h0000_0013);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("bubble_count", {29'b0, bus.count}, 32'h0);
    write(32'h900, 32'h0000_0313, 1'b0);
    write(32'h904, 32'h0000_8082, 1'b1);
    check("prerst_count", {29'b0, bus.count}, 32'h2);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h908, 32'h0000_0413);
    sb.delete();
    cyc();
    check("midrst_count",     {29'b0, bus.count},     32'h0);
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("midrst_in_ready",  {31'b0, bus.in_ready},  32'h1);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
